// File: rtl/tx_anc_ppm_src.sv
// ----------------------------------------------------------------------------
// tx_anc_ppm_src
//   Transmit-side phase sequencer for the ANC pilot. Streams NCO phase words
//   as a periodic ramp of NSIG samples (step DPH_INC, first sample START_PH),
//   with tlast on the final sample of each period. Every PPM period of
//   accepted beats one sample is skipped (ppm_dir=1) or repeated (ppm_dir=0)
//   to track the far-end clock drift.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   srst             synchronous soft reset (active high)
//   en               level enable; sampled in IDLE to start a burst and at
//                    each period boundary to decide whether to continue
//   nsymb            periods per burst (0 = run until en drops)
//   ppm_val          beats between corrections (<=1 selects DEFAULT_PPM)
//   ppm_dir          1 = skip a sample, 0 = repeat a sample
//   m_phase_*        AXI-Stream master of phase words
//   busy             high while streaming
//   done             one-cycle pulse when a finite burst completes
//   symb_count       periods completed in the current burst
//   sigN             current sample index (1..NSIG)
// ----------------------------------------------------------------------------
module tx_anc_ppm_src #(
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned PPM_WIDTH   = 32,
  parameter int unsigned NSYMB_WIDTH = 16,
  parameter int unsigned NSIG        = 32768,
  parameter int unsigned DPH_INC     = 2048,
  parameter logic [PHASE_WIDTH-1:0] START_PH = '0,
  parameter int unsigned DEFAULT_PPM = 868393
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   srst,
  input  logic                   en,
  input  logic [NSYMB_WIDTH-1:0] nsymb,
  input  logic [PPM_WIDTH-1:0]   ppm_val,
  input  logic                   ppm_dir,
  output logic [PHASE_WIDTH-1:0] m_phase_tdata,
  output logic                   m_phase_tvalid,
  output logic                   m_phase_tlast,
  input  logic                   m_phase_tready,
  output logic                   busy,
  output logic                   done,
  output logic [NSYMB_WIDTH-1:0] symb_count,
  output logic [PHASE_WIDTH-1:0] sigN
);

  localparam logic [PHASE_WIDTH-1:0] NSIG_W   = PHASE_WIDTH'(NSIG);
  localparam logic [PHASE_WIDTH-1:0] NSIG_M1  = PHASE_WIDTH'(NSIG - 1);
  localparam logic [PHASE_WIDTH-1:0] DPH_W    = PHASE_WIDTH'(DPH_INC);
  localparam logic [PHASE_WIDTH-1:0] DPH2_W   = PHASE_WIDTH'(2 * DPH_INC);
  localparam logic [PHASE_WIDTH-1:0] ONE_SIG  = PHASE_WIDTH'(1);
  localparam logic [PPM_WIDTH-1:0]   ONE_PPM  = PPM_WIDTH'(1);
  localparam logic [PPM_WIDTH-1:0]   DEF_PPM  = PPM_WIDTH'(DEFAULT_PPM);
  localparam logic [NSYMB_WIDTH-1:0] ONE_SYMB = NSYMB_WIDTH'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 state_q,  state_d;
  logic [PHASE_WIDTH-1:0] sig_q,    sig_d;
  logic [PHASE_WIDTH-1:0] ph_q,     ph_d;
  logic [PPM_WIDTH-1:0]   track_q,  track_d;
  logic [PPM_WIDTH-1:0]   period_q, period_d;
  logic [NSYMB_WIDTH-1:0] symb_q,   symb_d;
  logic [NSYMB_WIDTH-1:0] nsymb_q,  nsymb_d;
  logic                   dir_q,    dir_d;
  logic                   rep_q,    rep_d;   // current beat is a repeated sample
  logic                   done_q,   done_d;

  logic                   hs;
  logic                   at_period;
  logic [PPM_WIDTH-1:0]   track_inc;
  logic [NSYMB_WIDTH-1:0] symb_inc;

  assign m_phase_tvalid = (state_q == S_RUN);
  assign m_phase_tlast  = (state_q == S_RUN) && (sig_q == NSIG_W) && !rep_q;
  assign m_phase_tdata  = ph_q;
  assign busy           = (state_q == S_RUN);
  assign done           = done_q;
  assign symb_count     = symb_q;
  assign sigN           = sig_q;

  assign hs        = m_phase_tvalid & m_phase_tready;
  assign at_period = (track_q == period_q);
  // Tracker saturates at the period so a correction that cannot be applied
  // near the end of a period stays pending until the next eligible beat.
  assign track_inc = at_period ? period_q : track_q + ONE_PPM;
  assign symb_inc  = symb_q + ONE_SYMB;

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    ph_d     = ph_q;
    track_d  = track_q;
    period_d = period_q;
    symb_d   = symb_q;
    nsymb_d  = nsymb_q;
    dir_d    = dir_q;
    rep_d    = rep_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d  = S_RUN;
          period_d = (ppm_val <= ONE_PPM) ? DEF_PPM : ppm_val;
          dir_d    = ppm_dir;
          nsymb_d  = nsymb;
          sig_d    = ONE_SIG;
          ph_d     = START_PH;
          track_d  = ONE_PPM;
          symb_d   = '0;
          rep_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (hs) begin
          if (sig_q == NSIG_W) begin
            // Period boundary: restart the ramp; finite bursts take priority
            // over en so a burst always runs its full count while en is high.
            sig_d   = ONE_SIG;
            ph_d    = START_PH;
            symb_d  = symb_inc;
            track_d = track_inc;
            rep_d   = 1'b0;
            if ((nsymb_q != '0) && (symb_inc == nsymb_q)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else if (!en) begin
              state_d = S_IDLE;
            end
          end else if (at_period && (sig_q < NSIG_M1) && !rep_q) begin
            // Correction only below NSIG-1 so neither a skip nor a repeat can
            // land on or jump over the tlast sample.
            track_d = ONE_PPM;
            if (dir_q) begin
              sig_d = sig_q + PHASE_WIDTH'(2);
              ph_d  = ph_q + DPH2_W;
            end else begin
              rep_d = 1'b1;
            end
          end else begin
            sig_d   = sig_q + ONE_SIG;
            ph_d    = ph_q + DPH_W;
            track_d = track_inc;
            rep_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sig_q    <= ONE_SIG;
      ph_q     <= START_PH;
      track_q  <= ONE_PPM;
      period_q <= DEF_PPM;
      symb_q   <= '0;
      nsymb_q  <= '0;
      dir_q    <= 1'b0;
      rep_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (srst) begin
      state_q  <= S_IDLE;
      sig_q    <= ONE_SIG;
      ph_q     <= START_PH;
      track_q  <= ONE_PPM;
      period_q <= DEF_PPM;
      symb_q   <= '0;
      nsymb_q  <= '0;
      dir_q    <= 1'b0;
      rep_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      ph_q     <= ph_d;
      track_q  <= track_d;
      period_q <= period_d;
      symb_q   <= symb_d;
      nsymb_q  <= nsymb_d;
      dir_q    <= dir_d;
      rep_q    <= rep_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_tx_anc_ppm_src.sv
// ----------------------------------------------------------------------------
// tb_tx_anc_ppm_src
//   Directed bench for tx_anc_ppm_src with NSIG=8, DPH_INC=2048, START_PH=0.
//   Expected sample-index sequences are hand-written nibble strings; the
//   expected phase of each beat is (sigN-1)*2048 and tlast is sigN==8.
// ----------------------------------------------------------------------------
module tb_tx_anc_ppm_src;
  localparam int PW  = 24;
  localparam int NS  = 8;
  localparam int DPH = 2048;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          srst = 1'b0;
  logic          en = 1'b0;
  logic [15:0]   nsymb = '0;
  logic [31:0]   ppm_val = '0;
  logic          ppm_dir = 1'b0;
  logic [PW-1:0] tdata;
  logic          tvalid, tlast;
  logic          tready = 1'b1;
  logic          busy, done;
  logic [15:0]   symb_count;
  logic [PW-1:0] sig_n;

  tx_anc_ppm_src #(
    .PHASE_WIDTH(PW), .PPM_WIDTH(32), .NSYMB_WIDTH(16), .NSIG(NS),
    .DPH_INC(DPH), .START_PH(24'h000000), .DEFAULT_PPM(868393)
  ) dut (
    .clk(clk), .reset_n(reset_n), .srst(srst), .en(en), .nsymb(nsymb),
    .ppm_val(ppm_val), .ppm_dir(ppm_dir),
    .m_phase_tdata(tdata), .m_phase_tvalid(tvalid), .m_phase_tlast(tlast),
    .m_phase_tready(tready), .busy(busy), .done(done),
    .symb_count(symb_count), .sigN(sig_n)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // accepted-beat monitor, sampled on the falling edge
  int   q_sig[$];
  int   q_dat[$];
  bit   q_last[$];
  int   done_cnt  = 0;
  int   done_beat = -1;
  bit   bp_on     = 1'b0;
  bit   stall_prev = 1'b0;
  logic [PW-1:0] prev_dat;
  logic          prev_last;

  initial forever begin
    @(negedge clk);
    if (tvalid && tready) begin
      q_sig.push_back(int'(sig_n));
      q_dat.push_back(int'(tdata));
      q_last.push_back(tlast);
    end
    if (done) begin
      done_cnt++;
      done_beat = q_sig.size();
    end
    if (bp_on && stall_prev && tvalid) begin
      chk("hold_data", 32'(tdata), 32'(prev_dat));
      chk("hold_last", 32'(tlast), 32'(prev_last));
    end
    stall_prev = tvalid && !tready;
    prev_dat   = tdata;
    prev_last  = tlast;
  end

  initial forever begin
    @(posedge clk);
    #1;
    tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic start(input logic [31:0] pv, input logic d, input logic [15:0] ns);
    @(posedge clk);
    #1;
    ppm_val = pv;
    ppm_dir = d;
    nsymb   = ns;
    q_sig.delete();
    q_dat.delete();
    q_last.delete();
    done_cnt  = 0;
    done_beat = -1;
    en = 1'b1;
  endtask

  task automatic wait_beats(input int nb, input int maxc);
    int i;
    i = 0;
    while (q_sig.size() < nb && i < maxc) begin
      @(negedge clk);
      i++;
    end
    if (q_sig.size() < nb) chk("beat_timeout", 32'(q_sig.size()), 32'(nb));
  endtask

  task automatic wait_idle(input int maxc);
    int i;
    i = 0;
    @(negedge clk);
    while ((busy || tvalid) && i < maxc) begin
      @(negedge clk);
      i++;
    end
    chk("idle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_seq(input logic [127:0] s, input int n);
    int sv;
    chk("beats", 32'(q_sig.size()), 32'(n));
    for (int i = 0; i < n && i < q_sig.size(); i++) begin
      sv = int'(s[4*(n-1-i) +: 4]);
      chk("sig",  32'(q_sig[i]),  32'(sv));
      chk("data", 32'(q_dat[i]),  32'((sv - 1) * DPH));
      chk("last", 32'(q_last[i]), 32'(sv == NS));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast",  32'(tlast),  32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_tdata",  32'(tdata),  32'd0);
    chk("rst_sign",   32'(sig_n),  32'd1);
    chk("rst_symb",   32'(symb_count), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // two-period finite burst, default ppm (no correction)
    start(32'd0, 1'b0, 16'd2);
    wait_beats(9, 200);
    en = 1'b0;
    wait_idle(200);
    check_seq(128'h1234567812345678, 16);
    chk("t1_done_cnt",  32'(done_cnt), 32'd1);
    chk("t1_done_beat", 32'(done_beat), 32'd16);
    chk("t1_symb",      32'(symb_count), 32'd2);

    // skip every 5 beats, continuous, en dropped in period 2
    start(32'd5, 1'b1, 16'd0);
    wait_beats(9, 200);
    en = 1'b0;
    wait_idle(200);
    check_seq(128'h12345781235678, 14);
    chk("t2_done_cnt", 32'(done_cnt), 32'd0);
    chk("t2_symb",     32'(symb_count), 32'd2);

    // repeat every 5 beats, one period
    start(32'd5, 1'b0, 16'd1);
    wait_beats(2, 200);
    en = 1'b0;
    wait_idle(200);
    check_seq(128'h123455678, 9);
    chk("t3_done_cnt",  32'(done_cnt), 32'd1);
    chk("t3_done_beat", 32'(done_beat), 32'd9);

    // correction due at sigN=7 is deferred into the next period
    start(32'd7, 1'b1, 16'd2);
    wait_beats(9, 200);
    en = 1'b0;
    wait_idle(200);
    check_seq(128'h123456781345678, 15);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);
    chk("t4_symb",     32'(symb_count), 32'd2);

    // random backpressure, three periods with skips
    bp_on = 1'b1;
    start(32'd5, 1'b1, 16'd3);
    wait_beats(16, 600);
    en = 1'b0;
    wait_idle(600);
    bp_on = 1'b0;
    check_seq(128'h123457812356781345678, 21);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_symb",     32'(symb_count), 32'd3);

    // asynchronous reset mid-period, off the clock edge
    start(32'd0, 1'b0, 16'd0);
    wait_beats(3, 200);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_tvalid", 32'(tvalid), 32'd0);
    chk("ar_tlast",  32'(tlast),  32'd0);
    chk("ar_busy",   32'(busy),   32'd0);
    chk("ar_tdata",  32'(tdata),  32'd0);
    chk("ar_sign",   32'(sig_n),  32'd1);
    chk("ar_symb",   32'(symb_count), 32'd0);
    en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // synchronous soft reset takes effect at the next edge
    start(32'd0, 1'b0, 16'd0);
    wait_beats(3, 200);
    srst = 1'b1;
    chk("sr_pre_tvalid", 32'(tvalid), 32'd1);
    @(posedge clk);
    #1;
    chk("sr_tvalid", 32'(tvalid), 32'd0);
    chk("sr_busy",   32'(busy),   32'd0);
    chk("sr_tdata",  32'(tdata),  32'd0);
    chk("sr_sign",   32'(sig_n),  32'd1);
    en   = 1'b0;
    srst = 1'b0;
    repeat (2) @(negedge clk);
    chk("sr_stay_idle", 32'(tvalid), 32'd0);

    // en dropped at sigN=3 finishes the period, no done
    start(32'd0, 1'b0, 16'd0);
    begin
      int i;
      i = 0;
      @(negedge clk);
      while (!(tvalid && sig_n == 24'd3) && i < 200) begin
        @(negedge clk);
        i++;
      end
      chk("t7_reach3", 32'(sig_n), 32'd3);
    end
    en = 1'b0;
    wait_idle(200);
    check_seq(128'h12345678, 8);
    chk("t7_done_cnt", 32'(done_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
